// File: rtl/clos_pkg.sv
// Shared types, default dimensions and helpers for the Clos CM path allocator.
package clos_pkg;

  localparam int MN = 2;        // central modules
  localparam int NN = 2;        // virtual circuits per port
  localparam int PN = 5;        // router ports
  localparam int RN = PN * NN;  // requesters

  typedef enum logic [2:0] {
    PORT_S = 3'd0,
    PORT_W = 3'd1,
    PORT_N = 3'd2,
    PORT_E = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } req_state_e;

  function automatic logic is_onehot(input logic [PN-1:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic int oh_to_idx(input logic [PN-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < PN; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int req_idx(input int p, input int v);
    return p * NN + v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-one finder: scans req starting at ptr, wrapping modulo W.
module rr_pick #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [W-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // First set bit at or after ptr, one-hot and encoded
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < W; i++) begin
      int j;
      j = (int'(ptr) + i) % W;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/clos_cm_alloc.sv
// Central-module path allocator: grants one IM->CM->OM path per cycle and
// holds it until the requester releases it.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no path owned; eligible for arbitration when req is legal
//   ST_HOLD | owns own_cm/own_dst; gnt and cms driven; waits for rel
module clos_cm_alloc
  import clos_pkg::*;
#(
  parameter int MN = clos_pkg::MN,
  parameter int NN = clos_pkg::NN,
  parameter int PN = clos_pkg::PN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PN*NN-1:0]    req,
  input  logic [PN*NN*PN-1:0] dest,
  input  logic [PN*NN-1:0]    rel,
  output logic [PN*NN-1:0]    gnt,
  output logic [PN*NN*MN-1:0] cms,
  output logic [PN*NN-1:0]    err
);

  localparam int RN  = PN * NN;
  localparam int RIW = $clog2(RN);
  localparam int MIW = (MN > 1) ? $clog2(MN) : 1;
  localparam int PIW = $clog2(PN);

  req_state_e     state   [RN];
  logic [MN-1:0]  im_busy [PN];
  logic [PN-1:0]  om_busy [MN];
  logic [MIW-1:0] own_cm  [RN];
  logic [PIW-1:0] own_dst [RN];
  logic [RIW-1:0] rp;
  logic [MIW-1:0] cp;

  logic [MN-1:0]  free_cm [RN];
  logic [PIW-1:0] dst_idx [RN];
  logic [RN-1:0]  elig;
  logic [RN-1:0]  illegal;

  logic [RN-1:0]  win_oh;
  logic [RIW-1:0] win_idx;
  logic           win_any;
  logic [MN-1:0]  win_free;
  logic [MN-1:0]  cm_oh;
  logic [MIW-1:0] cm_idx;
  logic           cm_any;

  // Legality and CM availability per requester, from registered busy bits only
  always_comb begin
    for (int r = 0; r < RN; r++) begin
      logic [PN-1:0] d;
      logic          legal;
      d          = dest[r*PN +: PN];
      legal      = is_onehot(d) && (d != (PN'(1) << (r / NN)));
      dst_idx[r] = PIW'(oh_to_idx(d));
      for (int m = 0; m < MN; m++) begin
        free_cm[r][m] = !im_busy[r/NN][m] && !om_busy[m][dst_idx[r]];
      end
      illegal[r] = (state[r] == ST_IDLE) && req[r] && !legal;
      elig[r]    = (state[r] == ST_IDLE) && req[r] && legal && (|free_cm[r]);
    end
  end

  assign win_free = free_cm[win_idx];

  rr_pick #(.W(RN), .IW(RIW)) u_req_pick (
    .req (elig),
    .ptr (rp),
    .gnt (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  rr_pick #(.W(MN), .IW(MIW)) u_cm_pick (
    .req (win_free),
    .ptr (cp),
    .gnt (cm_oh),
    .idx (cm_idx),
    .any (cm_any)
  );

  // Per-requester FSMs, busy bits and pointers; releases are applied before the
  // allocation so a bit set for a new owner survives any same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < RN; r++) begin
        state[r]   <= ST_IDLE;
        own_cm[r]  <= '0;
        own_dst[r] <= '0;
      end
      for (int p = 0; p < PN; p++) im_busy[p] <= '0;
      for (int m = 0; m < MN; m++) om_busy[m] <= '0;
      rp  <= '0;
      cp  <= '0;
      gnt <= '0;
      cms <= '0;
      err <= '0;
    end else begin
      err <= illegal;
      for (int r = 0; r < RN; r++) begin
        if (state[r] == ST_HOLD && rel[r]) begin
          state[r]                       <= ST_IDLE;
          gnt[r]                         <= 1'b0;
          cms[r*MN +: MN]                <= '0;
          im_busy[r/NN][own_cm[r]]       <= 1'b0;
          om_busy[own_cm[r]][own_dst[r]] <= 1'b0;
        end
      end
      for (int r = 0; r < RN; r++) begin
        if (win_any && win_oh[r] && cm_any) begin
          state[r]                   <= ST_HOLD;
          gnt[r]                     <= 1'b1;
          cms[r*MN +: MN]            <= cm_oh;
          own_cm[r]                  <= cm_idx;
          own_dst[r]                 <= dst_idx[r];
          im_busy[r/NN][cm_idx]      <= 1'b1;
          om_busy[cm_idx][dst_idx[r]] <= 1'b1;
          rp <= RIW'((r + 1) % RN);
          cp <= MIW'((int'(cm_idx) + 1) % MN);
        end
      end
    end
  end

endmodule
